// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle between NUM_REQ producers, the arbiter and one uart_tx.
// master = arbiter side (drives req_ready/tx_valid/tx_data); slave = producers + transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_valid;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_ready;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx among NUM_REQ byte producers.
// One byte in flight; 1-cycle arbitration; producers stall on req_ready, the tx side waits on tx_ready.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_BITS  = 8,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 0,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_tx_arbiter_if.master  bus,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, DRAIN, GAP} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d, cand;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d, sel_data;
  logic                 last_q, last_d;
  logic                 rdy_q;
  logic                 found, accept, pkt_done;

  // uart_tx drops ready the cycle after it samples tx_valid; that falling edge is the acceptance.
  assign accept   = tx_valid_q && rdy_q && !bus.tx_ready;
  assign pkt_done = last_q || (byte_cnt_q == 8'(MAX_BURST));
  assign sel_data = bus.req_data[int'(grant_q)*DATA_BITS +: DATA_BITS];

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    bus.req_ready = '0;
    found         = 1'b0;
    cand          = '0;
    case (state_q)
      IDLE: begin
        // Search starts just after the previous winner so every requester gets a turn.
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = GW'((int'(grant_q) + k) % NUM_REQ);
          if (!found && bus.req_valid[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) begin
          byte_cnt_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        bus.req_ready[grant_q] = 1'b1;
        if (bus.req_valid[grant_q]) begin
          tx_data_d  = sel_data;
          last_d     = bus.req_last[grant_q];
          byte_cnt_d = byte_cnt_q + 8'd1;
          tx_valid_d = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.tx_ready) begin
          if (pkt_done) begin
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            state_d = FETCH;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= GW'(NUM_REQ - 1);
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      rdy_q      <= bus.tx_ready;
    end
  end

endmodule
